// File: rtl/cache_controller.sv
// Direct-mapped, write-back, write-allocate byte cache in front of a 2**ADDR_W x DATA_W memory.
// Optional build macro CACHE_STATS_EN adds saturating hit_count / miss_count outputs.
module cache_controller #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8,
  parameter int LINES  = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] data,
  input  logic              wren,
  output logic              ready,
  output logic              done,
  output logic [DATA_W-1:0] q,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_wren,
`ifdef CACHE_STATS_EN
  output logic [15:0]       hit_count,
  output logic [15:0]       miss_count,
`endif
  input  logic [DATA_W-1:0] mem_q
);

  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = ADDR_W - IDX_W;

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] LOOKUP    = 3'd1;
  localparam logic [2:0] WRITEBACK = 3'd2;
  localparam logic [2:0] ALLOCATE  = 3'd3;
  localparam logic [2:0] FILL      = 3'd4;

  logic [2:0]        state_r;
  logic [ADDR_W-1:0] req_addr_r;
  logic [DATA_W-1:0] req_data_r;
  logic              req_wren_r;
  logic              refill_r;
  logic [LINES-1:0]  valid_r;
  logic [LINES-1:0]  dirty_r;
  logic [TAG_W-1:0]  tag_r  [LINES];
  logic [DATA_W-1:0] line_r [LINES];
  logic [DATA_W-1:0] q_r;
  logic              done_r;
  logic [ADDR_W-1:0] mem_address_r;
  logic [DATA_W-1:0] mem_data_r;
  logic              mem_wren_r;

  logic [IDX_W-1:0]  idx_s;
  logic [TAG_W-1:0]  req_tag_s;
  logic              hit_s;
  logic              victim_dirty_s;

  assign idx_s          = req_addr_r[IDX_W-1:0];
  assign req_tag_s      = req_addr_r[ADDR_W-1:IDX_W];
  assign hit_s          = valid_r[idx_s] && (tag_r[idx_s] == req_tag_s);
  assign victim_dirty_s = valid_r[idx_s] && dirty_r[idx_s];

  assign ready       = (state_r == IDLE);
  assign done        = done_r;
  assign q           = q_r;
  assign mem_address = mem_address_r;
  assign mem_data    = mem_data_r;
  assign mem_wren    = mem_wren_r;

  // Controller FSM together with the line store and the memory-port registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r       <= IDLE;
      req_addr_r    <= {ADDR_W{1'b0}};
      req_data_r    <= {DATA_W{1'b0}};
      req_wren_r    <= 1'b0;
      refill_r      <= 1'b0;
      valid_r       <= {LINES{1'b0}};
      dirty_r       <= {LINES{1'b0}};
      q_r           <= {DATA_W{1'b0}};
      done_r        <= 1'b0;
      mem_address_r <= {ADDR_W{1'b0}};
      mem_data_r    <= {DATA_W{1'b0}};
      mem_wren_r    <= 1'b0;
      for (int i = 0; i < LINES; i++) begin
        tag_r[i]  <= {TAG_W{1'b0}};
        line_r[i] <= {DATA_W{1'b0}};
      end
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (req) begin
            req_addr_r <= address;
            req_data_r <= data;
            req_wren_r <= wren;
            refill_r   <= 1'b0;
            state_r    <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (hit_s) begin
            if (req_wren_r) begin
              line_r[idx_s]  <= req_data_r;
              dirty_r[idx_s] <= 1'b1;
            end else begin
              q_r <= line_r[idx_s];
            end
            done_r  <= 1'b1;
            state_r <= IDLE;
          end else if (victim_dirty_s) begin
            // Evict the old owner of this index before refilling it.
            mem_address_r <= {tag_r[idx_s], idx_s};
            mem_data_r    <= line_r[idx_s];
            mem_wren_r    <= 1'b1;
            state_r       <= WRITEBACK;
          end else begin
            mem_address_r <= req_addr_r;
            state_r       <= ALLOCATE;
          end
        end
        WRITEBACK: begin
          mem_wren_r    <= 1'b0;
          mem_address_r <= req_addr_r;
          state_r       <= ALLOCATE;
        end
        ALLOCATE: begin
          state_r <= FILL;
        end
        FILL: begin
          line_r[idx_s]  <= mem_q;
          tag_r[idx_s]   <= req_tag_s;
          valid_r[idx_s] <= 1'b1;
          dirty_r[idx_s] <= 1'b0;
          refill_r       <= 1'b1;
          state_r        <= LOOKUP;
        end
        default: begin
          mem_wren_r <= 1'b0;
          state_r    <= IDLE;
        end
      endcase
    end
  end

`ifdef CACHE_STATS_EN
  // One count per request: the lookup that follows a fill is not a new hit.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hit_count  <= 16'h0000;
      miss_count <= 16'h0000;
    end else if (state_r == LOOKUP) begin
      if (!hit_s) begin
        if (miss_count != 16'hFFFF) miss_count <= miss_count + 16'h0001;
      end else if (!refill_r) begin
        if (hit_count != 16'hFFFF) hit_count <= hit_count + 16'h0001;
      end
    end
  end
`endif

endmodule

// File: tb/tb_cache_controller.sv
// Scoreboard bench for cache_controller: transaction-level cache model plus a flat memory view.
module tb_cache_controller;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       req = 1'b0;
  logic [4:0] address = 5'h00;
  logic [7:0] data = 8'h00;
  logic       wren = 1'b0;
  logic       ready, done, mem_wren;
  logic [7:0] q, mem_data;
  logic [7:0] mem_q = 8'h00;
  logic [4:0] mem_address;
`ifdef CACHE_STATS_EN
  logic [15:0] hit_count, miss_count;
  int exp_hits = 0, exp_misses = 0;
`endif

  cache_controller dut (
    .clock(clock), .reset_n(reset_n), .req(req), .address(address), .data(data),
    .wren(wren), .ready(ready), .done(done), .q(q), .mem_address(mem_address),
    .mem_data(mem_data), .mem_wren(mem_wren),
`ifdef CACHE_STATS_EN
    .hit_count(hit_count), .miss_count(miss_count),
`endif
    .mem_q(mem_q)
  );

  always #5 clock = ~clock;

  // 32x8 memory: reads on posedge, writes on negedge.
  logic [7:0] mem [32];
  always @(posedge clock) mem_q <= mem[mem_address];
  always @(negedge clock) if (mem_wren) mem[mem_address] <= mem_data;

  typedef struct {
    logic [7:0] q;
    int         lat;
    int         issue;
  } exp_t;

  exp_t        sbq[$];
  logic [12:0] wbq[$];
  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;

  always @(posedge clock) cyc <= cyc + 1;

  // Reference state: processor-visible bytes, backing memory, and per-index cache occupancy.
  logic [7:0] view [32];
  logic [7:0] ref_mem [32];
  logic       mv [4];
  logic       md [4];
  logic [2:0] mt [4];
  logic [7:0] mdat [4];
  logic [7:0] last_q;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  exp_t        mon_e;
  logic [12:0] mon_wb;
  always @(negedge clock) begin
    if (reset_n) begin
      if (done) begin
        if (sbq.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_done: got done=1, expected no completion (cycle %0d)", cyc);
        end else begin
          mon_e = sbq.pop_front();
          chk("latency", cyc - mon_e.issue + 1, mon_e.lat);
          chk("q", {24'h0, q}, {24'h0, mon_e.q});
        end
      end
      if (mem_wren) begin
        if (wbq.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_mem_wren: got addr %0h data %0h, expected mem_wren=0", mem_address, mem_data);
        end else begin
          mon_wb = wbq.pop_front();
          chk("writeback", {19'h0, mem_address, mem_data}, {19'h0, mon_wb});
        end
      end
    end
  end

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      mv[i] = 1'b0; md[i] = 1'b0;
    end
    for (int i = 0; i < 32; i++) view[i] = ref_mem[i];
    last_q = 8'h00;
`ifdef CACHE_STATS_EN
    exp_hits = 0; exp_misses = 0;
`endif
  endtask

  task automatic do_req(input logic [4:0] a, input logic [7:0] d, input logic w, input bit glitch);
    exp_t e;
    int idx;
    int k;
    k = 0;
    @(negedge clock);
    while (!ready && k < 50) begin
      @(negedge clock); k++;
    end
    if (!ready) begin
      chk("ready_timeout", 32'd0, 32'd1);
      return;
    end
    idx = int'(a[1:0]);
    if (mv[idx] && mt[idx] == a[4:2]) begin
      e.lat = 2;
`ifdef CACHE_STATS_EN
      exp_hits++;
`endif
    end else begin
`ifdef CACHE_STATS_EN
      exp_misses++;
`endif
      if (mv[idx] && md[idx]) begin
        e.lat = 6;
        wbq.push_back({mt[idx], a[1:0], mdat[idx]});
        ref_mem[{mt[idx], a[1:0]}] = mdat[idx];
      end else begin
        e.lat = 5;
      end
      mv[idx] = 1'b1; md[idx] = 1'b0; mt[idx] = a[4:2]; mdat[idx] = ref_mem[a];
    end
    if (w) begin
      mdat[idx] = d; md[idx] = 1'b1; view[a] = d;
    end else begin
      last_q = view[a];
    end
    e.q = last_q;
    e.issue = cyc + 1;
    sbq.push_back(e);
    req = 1'b1; address = a; data = d; wren = w;
    @(negedge clock);
    req = 1'b0;
    k = 0;
    while (!done && k < 20) begin
      if (glitch && k == 1) begin
        req = 1'b1; address = a ^ 5'h10; wren = 1'b0;
      end else begin
        req = 1'b0;
      end
      @(negedge clock); k++;
    end
    req = 1'b0;
    if (!done) chk("done_timeout", 32'd0, 32'd1);
`ifdef CACHE_STATS_EN
    chk("hit_count", {16'h0, hit_count}, exp_hits);
    chk("miss_count", {16'h0, miss_count}, exp_misses);
`endif
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 32; i++) begin
      mem[i] = 8'(i) + 8'h10;
      ref_mem[i] = 8'(i) + 8'h10;
    end
    model_reset();
    #22;
    chk("reset_q", {24'h0, q}, 32'h0);
    chk("reset_done", {31'h0, done}, 32'h0);
    chk("reset_mem_wren", {31'h0, mem_wren}, 32'h0);
    chk("reset_mem_address", {27'h0, mem_address}, 32'h0);
    chk("reset_mem_data", {24'h0, mem_data}, 32'h0);
    chk("reset_ready", {31'h0, ready}, 32'h1);
    reset_n = 1'b1;

    do_req(5'h05, 8'h00, 1'b0, 1'b0);
    chk("t1_q", {24'h0, q}, 32'h15);
    do_req(5'h05, 8'h00, 1'b0, 1'b0);
    do_req(5'h05, 8'hAA, 1'b1, 1'b0);
    do_req(5'h05, 8'h00, 1'b0, 1'b0);
    chk("t2_q", {24'h0, q}, 32'hAA);
    do_req(5'h09, 8'h00, 1'b0, 1'b0);
    chk("t3_q", {24'h0, q}, 32'h19);
    chk("t3_mem5", {24'h0, mem[5]}, 32'hAA);
    do_req(5'h02, 8'h55, 1'b1, 1'b0);
    do_req(5'h02, 8'h00, 1'b0, 1'b0);
    chk("t4_q", {24'h0, q}, 32'h55);
    chk("t4_mem2", {24'h0, mem[2]}, 32'h12);
    do_req(5'h13, 8'h00, 1'b0, 1'b1);
    repeat (8) @(negedge clock);
    chk("t6_queue_empty", sbq.size(), 32'd0);

    // Clean miss on index 1, then reset while the line is filling.
    @(negedge clock);
    req = 1'b1; address = 5'h0D; wren = 1'b0;
    @(posedge clock); #1 req = 1'b0;
    @(posedge clock);
    @(posedge clock); #1;
    reset_n = 1'b0;
    #1;
    chk("t5_q", {24'h0, q}, 32'h0);
    chk("t5_done", {31'h0, done}, 32'h0);
    chk("t5_mem_wren", {31'h0, mem_wren}, 32'h0);
    chk("t5_mem_address", {27'h0, mem_address}, 32'h0);
    chk("t5_mem_data", {24'h0, mem_data}, 32'h0);
    model_reset();
    @(negedge clock); @(negedge clock);
    reset_n = 1'b1;
    do_req(5'h05, 8'h00, 1'b0, 1'b0);
    chk("t5_reread_q", {24'h0, q}, 32'hAA);

    for (int n = 0; n < 200; n++)
      do_req(5'($urandom_range(0, 31)), 8'($urandom), 1'($urandom_range(0, 1)), 1'b0);

    repeat (8) @(negedge clock);
    chk("final_sbq_empty", sbq.size(), 32'd0);
    chk("final_wbq_empty", wbq.size(), 32'd0);
    for (int i = 0; i < 32; i++) chk("final_mem", {24'h0, mem[i]}, {24'h0, ref_mem[i]});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
